ase_umsg_scheduler: RTL and testbench



---
 rtl/ase_umsg_scheduler.sv | 160 ++++++++++++++++
 tb/tb_ase_umsg_scheduler.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ase_umsg_scheduler.sv
// UMsg hint/data sequencer for the RX0 path: per-slot timers and hint/data states,
// round-robin selection of pending slots into one registered valid/grant output.
module ase_umsg_scheduler #(
  parameter int NUM_UMSG   = 8,
  parameter int UMSG_ID_W  = $clog2(NUM_UMSG),
  parameter int HINT_DELAY = 16,
  parameter int DATA_DELAY = 32,
  parameter int TIMER_W    = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 umsg_cmd_valid,
  output logic                 umsg_cmd_ready,
  input  logic [UMSG_ID_W-1:0] umsg_cmd_id,
  input  logic [511:0]         umsg_cmd_data,
  input  logic [NUM_UMSG-1:0]  umsg_hint_enable,
  output logic                 rx_umsg_valid,
  input  logic                 rx_umsg_grant,
  output logic [27:0]          rx_umsg_hdr,
  output logic [511:0]         rx_umsg_data,
  output logic                 busy
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_SEND_HINT = 2'd1,
    S_WAITING   = 2'd2,
    S_SEND_DATA = 2'd3
  } slot_state_t;

  logic [NUM_UMSG-1:0]  hint_pend;
  logic [NUM_UMSG-1:0]  data_pend;
  logic [NUM_UMSG-1:0]  slot_active;
  logic [NUM_UMSG-1:0]  any_pend_vec;
  logic [511:0]         slot_line [NUM_UMSG];

  logic                 cmd_fire;
  logic                 load_fire;
  logic                 any_pend;
  logic                 win_is_hint;
  logic [UMSG_ID_W-1:0] winner;
  logic [UMSG_ID_W-1:0] rr_ptr_reg;
  logic                 valid_reg;
  logic [27:0]          hdr_reg;
  logic [511:0]         data_reg;

  // A slot in SendData already has its line committed, so it refuses new writes.
  assign umsg_cmd_ready = rst_n && !data_pend[umsg_cmd_id];
  assign cmd_fire       = umsg_cmd_valid && umsg_cmd_ready;
  assign any_pend_vec   = hint_pend | data_pend;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_UMSG; gi++) begin : g_slot
      slot_state_t          state_reg;
      logic [TIMER_W-1:0]   timer_reg;
      logic [511:0]         line_reg;
      logic                 accept;
      logic                 load;

      assign accept = cmd_fire && (umsg_cmd_id == UMSG_ID_W'(gi));
      assign load   = load_fire && (winner == UMSG_ID_W'(gi));

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          state_reg <= S_IDLE;
          timer_reg <= '0;
        end else begin
          case (state_reg)
            S_IDLE: begin
              if (accept) begin
                if (umsg_hint_enable[gi]) begin
                  state_reg <= S_SEND_HINT;
                  timer_reg <= TIMER_W'(HINT_DELAY);
                end else begin
                  state_reg <= S_WAITING;
                  timer_reg <= TIMER_W'(DATA_DELAY);
                end
              end
            end
            S_SEND_HINT: begin
              if (load) begin
                state_reg <= S_WAITING;
                timer_reg <= TIMER_W'(DATA_DELAY);
              end else if (timer_reg != '0) begin
                timer_reg <= timer_reg - 1'b1;
              end
            end
            S_WAITING: begin
              // Enter SendData on the edge the timer reaches zero, so data is
              // pending exactly DATA_DELAY cycles after the timer was loaded.
              if (timer_reg <= TIMER_W'(1)) begin
                state_reg <= S_SEND_DATA;
                timer_reg <= '0;
              end else begin
                timer_reg <= timer_reg - 1'b1;
              end
            end
            S_SEND_DATA: begin
              if (load) state_reg <= S_IDLE;
            end
            default: begin
              state_reg <= S_IDLE;
              timer_reg <= '0;
            end
          endcase
        end
      end

      // Any accept (including coalescing ones) simply refreshes the stored line.
      always_ff @(posedge clk) begin
        if (accept) line_reg <= umsg_cmd_data;
      end

      assign hint_pend[gi]   = (state_reg == S_SEND_HINT) && (timer_reg == '0);
      assign data_pend[gi]   = (state_reg == S_SEND_DATA);
      assign slot_active[gi] = (state_reg != S_IDLE);
      assign slot_line[gi]   = line_reg;
    end
  endgenerate

  always_comb begin
    int idx;
    any_pend = 1'b0;
    winner   = rr_ptr_reg;
    idx      = 0;
    for (int k = 0; k < NUM_UMSG; k++) begin
      idx = (int'(rr_ptr_reg) + k) % NUM_UMSG;
      if (!any_pend && any_pend_vec[idx]) begin
        any_pend = 1'b1;
        winner   = UMSG_ID_W'(idx);
      end
    end
  end

  assign win_is_hint = hint_pend[winner];
  assign load_fire   = (!valid_reg || rx_umsg_grant) && any_pend;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg  <= 1'b0;
      hdr_reg    <= '0;
      data_reg   <= '0;
      rr_ptr_reg <= '0;
    end else if (load_fire) begin
      valid_reg  <= 1'b1;
      hdr_reg    <= {8'h00, 4'hF, win_is_hint, 9'h000, 6'(winner)};
      data_reg   <= win_is_hint ? '0 : slot_line[winner];
      rr_ptr_reg <= (winner == UMSG_ID_W'(NUM_UMSG - 1)) ? '0 : winner + 1'b1;
    end else if (rx_umsg_grant) begin
      valid_reg  <= 1'b0;
    end
  end

  assign rx_umsg_valid = valid_reg;
  assign rx_umsg_hdr   = hdr_reg;
  assign rx_umsg_data  = data_reg;
  assign busy          = (|slot_active) || valid_reg;

endmodule

// File: tb/tb_ase_umsg_scheduler.sv
// Directed bench for ase_umsg_scheduler: scoreboard of expected messages checked
// on every valid&&grant transfer, plus reset, hold, ready and timing checks.
module tb_ase_umsg_scheduler;

  localparam int NUM_UMSG  = 8;
  localparam int UMSG_ID_W = 3;

  logic                 clk;
  logic                 rst_n;
  logic                 umsg_cmd_valid;
  logic                 umsg_cmd_ready;
  logic [UMSG_ID_W-1:0] umsg_cmd_id;
  logic [511:0]         umsg_cmd_data;
  logic [NUM_UMSG-1:0]  umsg_hint_enable;
  logic                 rx_umsg_valid;
  logic                 rx_umsg_grant;
  logic [27:0]          rx_umsg_hdr;
  logic [511:0]         rx_umsg_data;
  logic                 busy;

  ase_umsg_scheduler #(
    .NUM_UMSG(NUM_UMSG), .UMSG_ID_W(UMSG_ID_W),
    .HINT_DELAY(16), .DATA_DELAY(32), .TIMER_W(8)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .umsg_cmd_valid(umsg_cmd_valid), .umsg_cmd_ready(umsg_cmd_ready),
    .umsg_cmd_id(umsg_cmd_id), .umsg_cmd_data(umsg_cmd_data),
    .umsg_hint_enable(umsg_hint_enable),
    .rx_umsg_valid(rx_umsg_valid), .rx_umsg_grant(rx_umsg_grant),
    .rx_umsg_hdr(rx_umsg_hdr), .rx_umsg_data(rx_umsg_data),
    .busy(busy)
  );

  typedef struct {
    logic [27:0]  hdr;
    logic [511:0] data;
    int           at;     // expected transfer cycle, 0 = not timed
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   cyc         = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [27:0] mk_hdr(input int id, input bit hint);
    return {8'h00, 4'hF, hint, 9'h000, 6'(id)};
  endfunction

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic push(input int id, input bit hint, input logic [511:0] d, input int at);
    exp_t e;
    e.hdr  = mk_hdr(id, hint);
    e.data = hint ? '0 : d;
    e.at   = at;
    exp_q.push_back(e);
  endtask

  // Drives one command; returns the index of the edge that accepted it.
  task automatic send(input int id, input logic [511:0] d, input bit hint, output int t);
    umsg_cmd_id      = UMSG_ID_W'(id);
    umsg_cmd_data    = d;
    umsg_hint_enable = hint ? NUM_UMSG'(1 << id) : '0;
    umsg_cmd_valid   = 1'b1;
    #1;
    chk($sformatf("cmd_ready_id%0d", id), umsg_cmd_ready, 1);
    @(negedge clk);
    t = cyc;
    umsg_cmd_valid   = 1'b0;
    umsg_hint_enable = '0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain", exp_q.size(), 0);
  endtask

  // Scoreboard side: every transfer must match the head of the expected queue.
  always begin
    exp_t e;
    @(negedge clk);
    #2;
    if (rx_umsg_valid && rx_umsg_grant) begin
      vectors++;
      assert (exp_q.size() != 0) else begin
        miscompares++;
        $error("FAIL unexpected_msg cyc=%0d observed hdr=%0h expected no message", cyc, rx_umsg_hdr);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("msg_hdr", rx_umsg_hdr, e.hdr);
        chk("msg_data", rx_umsg_data, e.data);
        if (e.at != 0) chk("msg_cycle", cyc, e.at);
        $display("msg cyc=%0d hdr=%07h data[31:0]=%08h", cyc, rx_umsg_hdr, rx_umsg_data[31:0]);
      end
    end
  end

  logic [511:0] d_a5, d_db, d_x, d_y, d_z, d0, d3, d7, e0, e7, f4, f6;

  initial begin
    int t, t1, t2, ta, t0, tb7;
    d_a5 = {64{8'hA5}};  d_db = {16{32'hDEADBEEF}};
    d_x  = {64{8'h11}};  d_y  = {64{8'h22}};  d_z = {64{8'h33}};
    d0   = {64{8'h40}};  d3   = {64{8'h43}};  d7  = {64{8'h47}};
    e0   = {16{32'hE0E0_0001}};  e7 = {16{32'hE7E7_0007}};
    f4   = {64{8'hF4}};  f6   = {64{8'hF6}};

    rst_n = 1'b0; umsg_cmd_valid = 1'b0; umsg_cmd_id = '0;
    umsg_cmd_data = '0; umsg_hint_enable = '0; rx_umsg_grant = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_valid", rx_umsg_valid, 0);
    chk("rst_hdr", rx_umsg_hdr, 0);
    chk("rst_data", rx_umsg_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready_low", umsg_cmd_ready, 0);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("ready_after_rst", umsg_cmd_ready, 1);

    // No-hint message, grant tied high
    rx_umsg_grant = 1'b1;
    send(2, d_a5, 1'b0, t);
    push(2, 1'b0, d_a5, t + 33);
    wait_drain();
    repeat (3) @(negedge clk);
    #1;
    chk("busy_idle_after_id2", busy, 0);

    // Hint then data
    @(negedge clk);
    send(5, d_db, 1'b1, t);
    push(5, 1'b1, '0, t + 17);
    push(5, 1'b0, d_db, t + 50);
    wait_drain();

    // Coalescing overwrite and ready=0 in SendData
    @(negedge clk);
    send(1, d_x, 1'b0, t1);
    repeat (9) @(negedge clk);
    send(1, d_y, 1'b0, t2);
    chk("overwrite_gap", t2 - t1, 10);
    push(1, 1'b0, d_y, t1 + 33);
    while (cyc < t1 + 32) @(negedge clk);
    umsg_cmd_id = 3'd1; umsg_cmd_data = d_z; umsg_cmd_valid = 1'b1;
    #1;
    chk("ready_in_senddata", umsg_cmd_ready, 0);
    @(negedge clk);
    umsg_cmd_valid = 1'b0;
    wait_drain();
    repeat (40) @(negedge clk);

    // Contention after a fresh reset (rr_ptr = 0)
    #3 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rx_umsg_grant = 1'b0;
    @(negedge clk);
    send(0, d0, 1'b0, ta);
    send(3, d3, 1'b0, t);
    send(7, d7, 1'b0, t);
    push(0, 1'b0, d0, 0);
    push(3, 1'b0, d3, 0);
    push(7, 1'b0, d7, 0);
    while (cyc < ta + 35) @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      #1;
      chk("hold_valid", rx_umsg_valid, 1);
      chk("hold_hdr_id0", rx_umsg_hdr, mk_hdr(0, 1'b0));
      chk("hold_data_id0", rx_umsg_data, d0);
      @(negedge clk);
    end
    rx_umsg_grant = 1'b1;
    @(negedge clk);
    rx_umsg_grant = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("after_pulse_hdr_id3", rx_umsg_hdr, mk_hdr(3, 1'b0));
      chk("after_pulse_data_id3", rx_umsg_data, d3);
      @(negedge clk);
    end
    rx_umsg_grant = 1'b1;
    @(negedge clk);
    rx_umsg_grant = 1'b0;
    #1;
    chk("hold_hdr_id7", rx_umsg_hdr, mk_hdr(7, 1'b0));

    // Second round: new 7 and 0 pend behind the held id7, rr_ptr is 0
    @(negedge clk);
    send(7, e7, 1'b0, tb7);
    send(0, e0, 1'b0, t0);
    push(0, 1'b0, e0, 0);
    push(7, 1'b0, e7, 0);
    while (cyc < t0 + 34) @(negedge clk);
    #1;
    chk("round2_hold_hdr", rx_umsg_hdr, mk_hdr(7, 1'b0));
    chk("round2_hold_data", rx_umsg_data, d7);
    @(negedge clk);
    rx_umsg_grant = 1'b1;
    wait_drain();
    repeat (5) @(negedge clk);

    // Asynchronous reset while a message is held and another slot is Waiting
    rx_umsg_grant = 1'b0;
    send(4, f4, 1'b0, t);
    while (cyc < t + 34) @(negedge clk);
    #1;
    chk("pre_rst_valid", rx_umsg_valid, 1);
    chk("pre_rst_hdr", rx_umsg_hdr, mk_hdr(4, 1'b0));
    @(negedge clk);
    send(6, f6, 1'b0, t);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_valid", rx_umsg_valid, 0);
    chk("arst_hdr", rx_umsg_hdr, 0);
    chk("arst_data", rx_umsg_data, 0);
    chk("arst_busy", busy, 0);
    chk("arst_ready", umsg_cmd_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    rx_umsg_grant = 1'b1;
    repeat (60) @(negedge clk);
    for (int i = 0; i < NUM_UMSG; i++) begin
      umsg_cmd_id = UMSG_ID_W'(i);
      #1;
      chk($sformatf("post_rst_ready_id%0d", i), umsg_cmd_ready, 1);
    end
    chk("post_rst_busy", busy, 0);
    chk("post_rst_queue", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
